cordic_quadrant_map: RTL and testbench
======================================

CORDIC_QUADRANT_MAP -- requirements
Module: cordic_quadrant_map

Interface
REQ-001 SHALL have parameter W, default 16, the data width of the phase, x, y and z paths.
REQ-002 SHALL have parameter K_INIT, default 16'sd4974, the initial x value: CORDIC gain compensation 0.607253 in Q2.13.
REQ-003 SHALL have parameter HALF_PI_RAD, default 12868, the value of pi/2 in Q2.13 radians, matching the arctan ROM scaling.
REQ-004 SHALL have port Clk, input, 1 bit, the clock; all logic is on the rising edge.
REQ-005 SHALL have port Reset, input, 1 bit, a synchronous active-high reset.
REQ-006 SHALL have port In_valid, input, 1 bit, meaning In_phase holds a valid sample.
REQ-007 SHALL have port In_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-008 SHALL have port In_phase, input, W bits, an unsigned phase where 2^W counts equal one full circle.
REQ-009 SHALL have port Out_valid, output, 1 bit, meaning the Out_* fields are valid.
REQ-010 SHALL have port Out_ready, input, 1 bit, meaning the downstream CORDIC feeder accepts this cycle.
REQ-011 SHALL have ports Out_x, Out_y, Out_z, output, signed W bits each, the initial x, y and z for the rotation pipeline.
REQ-012 SHALL have ports Out_cos_negate and Out_sin_negate, output, 1 bit each, the final-result sign flags.

Function
REQ-013 SHALL transfer a sample on the input side when In_valid and In_ready are both high, and on the output side when Out_valid and Out_ready are both high.
REQ-014 SHALL implement a 2-stage elastic pipeline:
- S1 performs the quadrant fold.
- S2 performs the phase-to-radian scaling.
- Each stage has its own valid bit.
REQ-015 SHALL let a stage load when it is empty or its contents leave this cycle; In_ready is S1 empty, or S1 advancing into S2.
REQ-016 SHALL give 2 cycles of latency from input handshake to Out_valid, with no downstream stall.
REQ-017 SHALL sustain 1 sample per cycle with Out_ready held high.
REQ-018 SHALL, in S1, split the phase into q = In_phase[15:14] and r = In_phase[13:0].
REQ-019 SHALL fold the quadrants as follows:
- q=0: s = r, cos_negate 0, sin_negate 0.
- q=1: s = r-16384, cos_negate 1, sin_negate 1.
- q=2: s = r, cos_negate 1, sin_negate 1.
- q=3: s = r-16384, cos_negate 0, sin_negate 0.
REQ-020 SHALL hold s as a signed 16-bit value in the range [-16384, 16383].
REQ-021 SHALL, in S2, compute Out_z = (s*HALF_PI_RAD + 8192) >>> 14 with a 31-bit signed product, arithmetic shift and no saturation.
REQ-022 SHALL drive Out_x = K_INIT and Out_y = 0, registered alongside z.
REQ-023 SHALL carry the negate flags with their sample through S1 and S2 unchanged.
REQ-024 SHALL hold every Out_* field stable while Out_valid is high and Out_ready is low.
REQ-025 SHALL neither drop nor duplicate samples and SHALL keep them in order.
REQ-026 SHALL, on a simultaneous S2 drain and S1 advance, load S2 from S1 in the same cycle with no bubble.
REQ-027 SHALL treat phase 0xFFFF as q=3, s=-1, giving Out_z=-1 (value -0.785 rounded), with no wrap error.

Reset
REQ-028 SHALL on Reset clear both stage valids, so that Out_valid=0 and In_ready=1 from the first cycle after Reset.
REQ-029 SHALL on Reset set Out_x=0, Out_y=0, Out_z=0, Out_cos_negate=0 and Out_sin_negate=0.
REQ-030 SHALL discard in-flight samples when Reset occurs mid-stream, with no partial output afterwards.
REQ-031 SHALL give Reset priority over any handshake in the same cycle.

Structure
REQ-032 SHALL take W, K_INIT, HALF_PI_RAD and the quadrant encoding constants from the shared package cordic_pkg, which the rotation pipeline also uses.
REQ-033 SHALL implement each stage register as one instance of a single sub-module, cordic_pipe_reg: a valid/ready register slice with a payload parameter.
REQ-034 SHALL use no multicycle paths, and the product SHALL be a single registered multiply.

Verification
REQ-035 Phase 0x0000 -> after 2 cycles: Out_x=4974, Out_y=0, Out_z=0, negates 0/0.
REQ-036 Phase 0x2000 -> Out_z=6434, negates 0/0; phase 0x6000 -> Out_z=-6434, negates 1/1.
REQ-037 Phase 0x4000 -> Out_z=-12868, negates 1/1; phase 0xC000 -> Out_z=-12868, negates 0/0; phase 0x8000 -> Out_z=0, negates 1/1.
REQ-038 Backpressure: 4 back-to-back samples with Out_ready low for 6 cycles ->
- In_ready falls after 2 accepts.
- Outputs are held stable.
- On release, all 4 emerge in order on consecutive cycles.
REQ-039 Reset asserted with 2 samples in flight -> next cycle Out_valid=0, all outputs 0, In_ready=1; no stale sample appears later.
REQ-040 Random phases streamed with random Out_ready -> each Out_z is within ±1 LSB of the reference model and flags match the quadrant.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC datapath: word width, gain
// compensation seed, pi/2 scaling and the quadrant encoding used to fold a
// full-circle phase into the rotation pipeline's convergence range.
package cordic_pkg;

  // Data width of the phase, x, y and z paths.
  localparam int CORDIC_W = 16;

  // Upper phase bits that select the quadrant.
  localparam int CORDIC_QUAD_BITS = 2;

  // CORDIC gain compensation 0.607253 in Q2.13, used as the starting x.
  localparam logic signed [15:0] CORDIC_K_INIT = 16'sd4974;

  // pi/2 in Q2.13 radians, matching the arctan ROM scaling.
  localparam int CORDIC_HALF_PI_RAD = 12868;

  // Quadrant index taken from the top two phase bits.
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  // Sign corrections applied to the final cos/sin results.
  typedef struct packed {
    logic cos_negate;
    logic sin_negate;
  } negate_t;

  // Quadrants 1 and 2 are reached by rotating half a turn from 3 and 0,
  // which flips the sign of both cos and sin.
  function automatic negate_t quad_negates(input quad_e q);
    negate_t n;
    n.cos_negate = (q == QUAD_1) || (q == QUAD_2);
    n.sin_negate = (q == QUAD_1) || (q == QUAD_2);
    return n;
  endfunction

  // Odd quadrants are folded by subtracting a quarter turn from the
  // remainder so the residual angle lands in [-pi/2, 0).
  function automatic logic quad_needs_offset(input quad_e q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

endpackage

// File: rtl/cordic_pipe_reg.sv
// One valid/ready register slice. The slice loads when it is empty or when
// its current contents leave downstream in the same cycle, so a chain of
// these runs at one item per clock without bubbles. Payload holds while
// stalled and clears to zero on reset.
module cordic_pipe_reg #(
  parameter int PW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [PW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [PW-1:0] dn_data
);

  logic          valid_q;
  logic [PW-1:0] data_q;
  logic          load;

  assign up_ready = !valid_q || dn_ready;
  assign load     = up_valid && up_ready;
  assign dn_valid = valid_q;
  assign dn_data  = data_q;

  // Occupancy follows the upstream valid whenever the slot is free to take
  // a new item; the payload only changes on an actual transfer in.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (up_ready) begin
        valid_q <= up_valid;
      end
      if (load) begin
        data_q <= up_data;
      end
    end
  end

endmodule

// File: rtl/cordic_quadrant_map.sv
// Front end of the CORDIC rotation pipeline. Stage 1 folds a full-circle
// phase into the residual range [-pi/2, pi/2) and records the final sign
// corrections; stage 2 scales the folded phase to Q2.13 radians and
// presents the initial x/y/z vector for the rotation stages.
module cordic_quadrant_map
  import cordic_pkg::*;
#(
  parameter int                  W           = CORDIC_W,
  parameter logic signed [W-1:0] K_INIT      = CORDIC_K_INIT,
  parameter int                  HALF_PI_RAD = CORDIC_HALF_PI_RAD
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                In_valid,
  output logic                In_ready,
  input  logic [W-1:0]        In_phase,
  output logic                Out_valid,
  input  logic                Out_ready,
  output logic signed [W-1:0] Out_x,
  output logic signed [W-1:0] Out_y,
  output logic signed [W-1:0] Out_z,
  output logic                Out_cos_negate,
  output logic                Out_sin_negate
);

  // Remainder bits below the quadrant field; one quadrant is 2^FRAC counts.
  localparam int FRAC  = W - CORDIC_QUAD_BITS;
  localparam int PRODW = 2 * W - 1;

  localparam logic signed [W-1:0]     QUARTER_COUNTS = W'(2 ** FRAC);
  localparam logic signed [PRODW-1:0] HALF_PI_EXT    = PRODW'(HALF_PI_RAD);
  localparam logic signed [PRODW-1:0] ROUND_HALF     = PRODW'(2 ** (FRAC - 1));

  typedef struct packed {
    logic signed [W-1:0] s;
    negate_t             neg;
  } s1_t;

  typedef struct packed {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    negate_t             neg;
  } s2_t;

  localparam int S1W = $bits(s1_t);
  localparam int S2W = $bits(s2_t);

  quad_e                     fold_quad;
  logic [FRAC-1:0]           fold_rem;
  s1_t                       s1_d;
  s1_t                       s1_q;
  logic [S1W-1:0]            s1_q_bits;
  logic                      s1_valid;
  logic                      s2_up_ready;

  logic signed [PRODW-1:0]   s_ext;
  logic signed [PRODW-1:0]   product;
  logic signed [PRODW-1:0]   rounded;
  s2_t                       s2_d;
  s2_t                       s2_q;
  logic [S2W-1:0]            s2_q_bits;

  // Quadrant fold: odd quadrants are pulled back by a quarter turn so the
  // residual is always in [-2^FRAC, 2^FRAC-1]; the top phase value folds to
  // -1 rather than wrapping.
  always_comb begin
    fold_quad = quad_e'(In_phase[W-1:FRAC]);
    fold_rem  = In_phase[FRAC-1:0];
    s1_d.s    = signed'({{CORDIC_QUAD_BITS{1'b0}}, fold_rem});
    if (quad_needs_offset(fold_quad)) begin
      s1_d.s = s1_d.s - QUARTER_COUNTS;
    end
    s1_d.neg = quad_negates(fold_quad);
  end

  cordic_pipe_reg #(
    .PW (S1W)
  ) u_stage1 (
    .Clk      (Clk),
    .Reset    (Reset),
    .up_valid (In_valid),
    .up_ready (In_ready),
    .up_data  (s1_d),
    .dn_valid (s1_valid),
    .dn_ready (s2_up_ready),
    .dn_data  (s1_q_bits)
  );

  assign s1_q = s1_t'(s1_q_bits);

  // Phase-to-radian scaling: one quadrant of counts maps to pi/2, so the
  // folded phase is multiplied by pi/2 and divided by 2^FRAC with
  // round-half-up. The product fits without saturation for any fold.
  always_comb begin
    s_ext    = PRODW'(s1_q.s);
    product  = s_ext * HALF_PI_EXT;
    rounded  = product + ROUND_HALF;
    s2_d.x   = K_INIT;
    s2_d.y   = '0;
    s2_d.z   = W'(rounded >>> FRAC);
    s2_d.neg = s1_q.neg;
  end

  cordic_pipe_reg #(
    .PW (S2W)
  ) u_stage2 (
    .Clk      (Clk),
    .Reset    (Reset),
    .up_valid (s1_valid),
    .up_ready (s2_up_ready),
    .up_data  (s2_d),
    .dn_valid (Out_valid),
    .dn_ready (Out_ready),
    .dn_data  (s2_q_bits)
  );

  assign s2_q           = s2_t'(s2_q_bits);
  assign Out_x          = s2_q.x;
  assign Out_y          = s2_q.y;
  assign Out_z          = s2_q.z;
  assign Out_cos_negate = s2_q.neg.cos_negate;
  assign Out_sin_negate = s2_q.neg.sin_negate;

endmodule

// File: tb/tb_cordic_quadrant_map.sv
// Bench for cordic_quadrant_map: directed phases, backpressure, mid-stream
// reset and a random stream, with a scoreboard queue checked at the output.
module tb_cordic_quadrant_map;

  logic               Clk;
  logic               Reset;
  logic               In_valid;
  logic               In_ready;
  logic [15:0]        In_phase;
  logic               Out_valid;
  logic               Out_ready;
  logic signed [15:0] Out_x;
  logic signed [15:0] Out_y;
  logic signed [15:0] Out_z;
  logic               Out_cos_negate;
  logic               Out_sin_negate;

  typedef struct {
    int   z;
    logic neg;
    bit   tol;
  } exp_t;

  exp_t exp_q[$];
  int   pop_log[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  bit   rand_en   = 0;

  cordic_quadrant_map dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .In_valid       (In_valid),
    .In_ready       (In_ready),
    .In_phase       (In_phase),
    .Out_valid      (Out_valid),
    .Out_ready      (Out_ready),
    .Out_x          (Out_x),
    .Out_y          (Out_y),
    .Out_z          (Out_z),
    .Out_cos_negate (Out_cos_negate),
    .Out_sin_negate (Out_sin_negate)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk) begin
    if (rand_en) begin
      #1;
      Out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Reference: fold by quadrant, then z = s * (pi/4) in Q2.13 counts.
  function automatic int modelZ(input logic [15:0] ph);
    logic [1:0]  q;
    logic [13:0] r;
    int          s;
    q = ph[15:14];
    r = ph[13:0];
    s = q[0] ? int'(r) - 16384 : int'(r);
    return int'($itor(s) * 3.14159265358979 / 4.0);
  endfunction

  function automatic logic modelNeg(input logic [15:0] ph);
    return (ph[15:14] == 2'd1) || (ph[15:14] == 2'd2);
  endfunction

  task automatic applyStimulus(input logic [15:0] phase, input int z_exp,
                               input logic neg, input bit tol);
    int   waited;
    exp_t e;
    waited   = 0;
    In_valid = 1'b1;
    In_phase = phase;
    @(negedge Clk);
    while (!In_ready && waited < 50) begin
      @(negedge Clk);
      waited++;
    end
    if (!In_ready) begin
      checkOutput("in_ready_timeout", int'(In_ready), 1);
    end else begin
      e.z   = z_exp;
      e.neg = neg;
      e.tol = tol;
      exp_q.push_back(e);
    end
    tick();
    In_valid = 1'b0;
  endtask

  task automatic drainWait;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge Clk);
      n++;
    end
    #1;
    checkOutput("drain", exp_q.size(), 0);
  endtask

  task automatic checkConsecutive(input string tag, input int count);
    checkOutput({tag, "_count"}, pop_log.size(), count);
    for (int i = 1; i < pop_log.size(); i++) begin
      checkOutput({tag, "_gap"}, pop_log[i] - pop_log[i-1], 1);
    end
  endtask

  // Output monitor: each accepted output is compared against the oldest
  // expectation in the scoreboard.
  always @(negedge Clk) begin
    exp_t e;
    int   diff;
    if (!Reset && Out_valid && Out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", int'(Out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        pop_log.push_back(cyc);
        checkOutput("out_x", int'(Out_x), 4974);
        checkOutput("out_y", int'(Out_y), 0);
        if (e.tol) begin
          diff = int'(Out_z) - e.z;
          checkOutput("out_z_tol", int'(diff <= 1 && diff >= -1), 1);
        end else begin
          checkOutput("out_z", int'(Out_z), e.z);
        end
        checkOutput("cos_neg", int'(Out_cos_negate), int'(e.neg));
        checkOutput("sin_neg", int'(Out_sin_negate), int'(e.neg));
      end
    end
  end

  initial begin
    logic [15:0] ph;
    Reset     = 1'b1;
    In_valid  = 1'b0;
    In_phase  = '0;
    Out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("rst_out_valid", int'(Out_valid), 0);
    checkOutput("rst_in_ready", int'(In_ready), 1);
    checkOutput("rst_x", int'(Out_x), 0);
    checkOutput("rst_y", int'(Out_y), 0);
    checkOutput("rst_z", int'(Out_z), 0);
    checkOutput("rst_cos", int'(Out_cos_negate), 0);
    checkOutput("rst_sin", int'(Out_sin_negate), 0);
    tick();

    // Latency: Out_valid two cycles after the input handshake
    Out_ready = 1'b1;
    applyStimulus(16'h0000, 0, 1'b0, 1'b0);
    @(negedge Clk);
    checkOutput("latency_1", int'(Out_valid), 0);
    @(negedge Clk);
    checkOutput("latency_2", int'(Out_valid), 1);
    tick();

    // Directed quadrant boundaries streamed back to back
    pop_log.delete();
    applyStimulus(16'h2000,   6434, 1'b0, 1'b0);
    applyStimulus(16'h6000,  -6434, 1'b1, 1'b0);
    applyStimulus(16'h4000, -12868, 1'b1, 1'b0);
    applyStimulus(16'hC000, -12868, 1'b0, 1'b0);
    applyStimulus(16'h8000,      0, 1'b1, 1'b0);
    applyStimulus(16'hFFFF,     -1, 1'b0, 1'b0);
    drainWait();
    checkConsecutive("throughput", 6);

    // Backpressure: two accepts fill the pipe, then outputs must hold
    Out_ready = 1'b0;
    applyStimulus(16'h2000,   6434, 1'b0, 1'b0);
    applyStimulus(16'h6000,  -6434, 1'b1, 1'b0);
    In_valid = 1'b1;
    In_phase = 16'h4000;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      checkOutput("bp_in_ready", int'(In_ready), 0);
      checkOutput("bp_hold_valid", int'(Out_valid), 1);
      checkOutput("bp_hold_z", int'(Out_z), 6434);
      checkOutput("bp_hold_cos", int'(Out_cos_negate), 0);
      tick();
    end
    pop_log.delete();
    Out_ready = 1'b1;
    applyStimulus(16'h4000, -12868, 1'b1, 1'b0);
    applyStimulus(16'hC000, -12868, 1'b0, 1'b0);
    drainWait();
    checkConsecutive("bp_release", 4);

    // Reset with two samples in flight, handshake attempted in that cycle
    Out_ready = 1'b0;
    applyStimulus(16'h2000,  6434, 1'b0, 1'b0);
    applyStimulus(16'h6000, -6434, 1'b1, 1'b0);
    Reset    = 1'b1;
    In_valid = 1'b1;
    In_phase = 16'h4000;
    exp_q.delete();
    tick();
    Reset    = 1'b0;
    In_valid = 1'b0;
    @(negedge Clk);
    checkOutput("mid_rst_valid", int'(Out_valid), 0);
    checkOutput("mid_rst_in_ready", int'(In_ready), 1);
    checkOutput("mid_rst_x", int'(Out_x), 0);
    checkOutput("mid_rst_z", int'(Out_z), 0);
    checkOutput("mid_rst_cos", int'(Out_cos_negate), 0);
    checkOutput("mid_rst_sin", int'(Out_sin_negate), 0);
    tick();
    pop_log.delete();
    Out_ready = 1'b1;
    repeat (10) tick();
    checkOutput("no_stale", pop_log.size(), 0);

    // Random phases with random downstream readiness
    rand_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      ph = 16'($urandom);
      applyStimulus(ph, modelZ(ph), modelNeg(ph), 1'b1);
    end
    rand_en = 1'b0;
    tick();
    Out_ready = 1'b1;
    drainWait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
